// File: rtl/io_handshake_ctrl.sv
// rtl/io_handshake_ctrl.sv - 4-phase external IN/OUT handshake bridge with a 2-entry input FIFO
// The input and output sides are independent FSMs; the processor side uses level requests answered by one-cycle pulses.
module io_handshake_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in,
   input  logic       inDataReady,
   output logic       inACK,
   output logic [7:0] out,
   output logic       outDataReady,
   input  logic       outACK,
   input  logic       rdReq,
   output logic [7:0] rdData,
   output logic       rdValid,
   input  logic       wrReq,
   input  logic [7:0] wrData,
   output logic       wrDone,
   output logic [1:0] inCount,
   output logic       outBusy
);

   typedef enum logic {I_IDLE, I_ACK} in_state_t;
   typedef enum logic [1:0] {O_IDLE, O_REQ, O_REL, O_DONE} out_state_t;

   in_state_t  in_state_q, in_state_d;
   out_state_t out_state_q, out_state_d;
   logic [7:0] slot0_q, slot0_d;
   logic [7:0] slot1_q, slot1_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;
   logic       rd_valid_q, rd_valid_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic [7:0] out_data_q, out_data_d;
   logic       push;
   logic       pop;
   logic [7:0] head;

   // Input side: capture only on the accepting edge, using pre-edge occupancy
   always_comb begin
      in_state_d = in_state_q;
      push       = 1'b0;
      case (in_state_q)
         I_IDLE: begin
            if (inDataReady && (count_q != 2'd2)) begin
               in_state_d = I_ACK;
               push       = 1'b1;
            end
         end
         I_ACK: begin
            if (!inDataReady) begin
               in_state_d = I_IDLE;
            end
         end
      endcase
   end

   // The rd_valid_q term spaces deliveries at least two cycles apart
   always_comb begin
      pop        = rdReq && !rd_valid_q && (count_q != 2'd0);
      head       = rd_ptr_q ? slot1_q : slot0_q;
      slot0_d    = slot0_q;
      slot1_d    = slot1_q;
      if (push) begin
         if (wr_ptr_q) begin
            slot1_d = in;
         end else begin
            slot0_d = in;
         end
      end
      wr_ptr_d   = wr_ptr_q ^ push;
      rd_ptr_d   = rd_ptr_q ^ pop;
      count_d    = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      rd_valid_d = pop;
      rd_data_d  = pop ? head : rd_data_q;
   end

   always_comb begin
      out_state_d = out_state_q;
      out_data_d  = out_data_q;
      case (out_state_q)
         O_IDLE: begin
            if (wrReq && !outACK) begin
               out_state_d = O_REQ;
               out_data_d  = wrData;
            end
         end
         O_REQ: begin
            if (outACK) begin
               out_state_d = O_REL;
            end
         end
         O_REL: begin
            if (!outACK) begin
               out_state_d = O_DONE;
            end
         end
         O_DONE: begin
            out_state_d = O_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_state_q  <= I_IDLE;
         out_state_q <= O_IDLE;
         slot0_q     <= 8'h00;
         slot1_q     <= 8'h00;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= 8'h00;
         out_data_q  <= 8'h00;
      end else begin
         in_state_q  <= in_state_d;
         out_state_q <= out_state_d;
         slot0_q     <= slot0_d;
         slot1_q     <= slot1_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         out_data_q  <= out_data_d;
      end
   end

   assign inACK        = (in_state_q == I_ACK);
   assign inCount      = count_q;
   assign rdValid      = rd_valid_q;
   assign rdData       = rd_data_q;
   assign out          = out_data_q;
   assign outDataReady = (out_state_q == O_REQ);
   assign wrDone       = (out_state_q == O_DONE);
   assign outBusy      = (out_state_q != O_IDLE);

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// tb/tb_io_handshake_ctrl.sv - directed and randomized bench for io_handshake_ctrl
// Reference model tracks a byte queue and handshake phases updated from pre-edge inputs.
module tb_io_handshake_ctrl;

   logic       clk;
   logic       reset;
   logic [7:0] in;
   logic       inDataReady;
   logic       inACK;
   logic [7:0] out;
   logic       outDataReady;
   logic       outACK;
   logic       rdReq;
   logic [7:0] rdData;
   logic       rdValid;
   logic       wrReq;
   logic [7:0] wrData;
   logic       wrDone;
   logic [1:0] inCount;
   logic       outBusy;

   int checks;
   int failures;

   logic [7:0] m_q[$];
   logic       m_in_ack;
   logic       m_rd_valid;
   logic [7:0] m_rd_data;
   int         m_phase;
   logic [7:0] m_out;

   io_handshake_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .in          (in),
      .inDataReady (inDataReady),
      .inACK       (inACK),
      .out         (out),
      .outDataReady(outDataReady),
      .outACK      (outACK),
      .rdReq       (rdReq),
      .rdData      (rdData),
      .rdValid     (rdValid),
      .wrReq       (wrReq),
      .wrData      (wrData),
      .wrDone      (wrDone),
      .inCount     (inCount),
      .outBusy     (outBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model with the inputs as they stand before the edge, then compare
   task automatic tick();
      logic push;
      logic pop;
      if (reset) begin
         m_q.delete();
         m_in_ack   = 1'b0;
         m_rd_valid = 1'b0;
         m_rd_data  = 8'h00;
         m_phase    = 0;
         m_out      = 8'h00;
      end else begin
         push = inDataReady && !m_in_ack && (m_q.size() < 2);
         pop  = rdReq && !m_rd_valid && (m_q.size() > 0);
         m_rd_valid = pop;
         if (pop) begin
            m_rd_data = m_q.pop_front();
         end
         if (push) begin
            m_q.push_back(in);
         end
         m_in_ack = m_in_ack ? inDataReady : push;
         case (m_phase)
            0: if (wrReq && !outACK) begin
                  m_phase = 1;
                  m_out   = wrData;
               end
            1: if (outACK) m_phase = 2;
            2: if (!outACK) m_phase = 3;
            default: m_phase = 0;
         endcase
      end
      @(posedge clk);
      #1;
      chk("inACK", 8'(inACK), 8'(m_in_ack));
      chk("inCount", 8'(inCount), 8'(m_q.size()));
      chk("rdValid", 8'(rdValid), 8'(m_rd_valid));
      chk("rdData", rdData, m_rd_data);
      chk("outDataReady", 8'(outDataReady), 8'(m_phase == 1));
      chk("wrDone", 8'(wrDone), 8'(m_phase == 3));
      chk("outBusy", 8'(outBusy), 8'(m_phase != 0));
      chk("out", out, m_out);
   endtask

   task automatic prod_send(input logic [7:0] b);
      int n;
      in          = b;
      inDataReady = 1'b1;
      n = 0;
      while (!inACK && n < 20) begin
         tick();
         n++;
      end
      chk("prod_ack_seen", 8'(inACK), 8'd1);
      inDataReady = 1'b0;
      n = 0;
      while (inACK && n < 20) begin
         tick();
         n++;
      end
      chk("prod_ack_release", 8'(inACK), 8'd0);
   endtask

   initial begin
      int n;
      int done_cnt;
      checks      = 0;
      failures    = 0;
      reset       = 1'b1;
      in          = 8'h00;
      inDataReady = 1'b0;
      outACK      = 1'b0;
      rdReq       = 1'b0;
      wrReq       = 1'b0;
      wrData      = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("reset_inCount", 8'(inCount), 8'd0);
      chk("reset_outs", {2'b0, inACK, outDataReady, rdValid, wrDone, outBusy, |out}, 8'd0);

      // Fill the FIFO, then a third request must stall until a read frees a slot
      prod_send(8'hA5);
      prod_send(8'h3C);
      chk("fifo_full", 8'(inCount), 8'd2);
      in          = 8'hFF;
      inDataReady = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("full_no_ack", 8'(inACK), 8'd0);
      rdReq = 1'b1;
      tick();
      chk("rd_first", rdData, 8'hA5);
      chk("rd_first_valid", 8'(rdValid), 8'd1);
      rdReq = 1'b0;
      tick();
      chk("ack_after_pop", 8'(inACK), 8'd1);
      inDataReady = 1'b0;
      tick();
      rdReq = 1'b1;
      tick();
      chk("rd_second", rdData, 8'h3C);
      rdReq = 1'b0;
      tick();
      rdReq = 1'b1;
      tick();
      chk("rd_third", rdData, 8'hFF);
      rdReq = 1'b0;
      tick();
      chk("drained", 8'(inCount), 8'd0);

      // Read pending on an empty FIFO
      rdReq = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("empty_wait", 8'(rdValid), 8'd0);
      in          = 8'h77;
      inDataReady = 1'b1;
      tick();
      inDataReady = 1'b0;
      tick();
      chk("rd_wait_valid", 8'(rdValid), 8'd1);
      chk("rd_wait_data", rdData, 8'h77);
      rdReq = 1'b0;
      tick();
      chk("rd_wait_count", 8'(inCount), 8'd0);

      // Output handshake, consumer acks after 3 cycles and releases after 2
      wrData   = 8'h5A;
      wrReq    = 1'b1;
      done_cnt = 0;
      tick();
      chk("out_req", 8'(outDataReady), 8'd1);
      for (int i = 0; i < 3; i++) begin
         wrData = 8'($urandom);
         tick();
         chk("out_held", out, 8'h5A);
      end
      outACK = 1'b1;
      tick();
      chk("out_rel", 8'(outDataReady), 8'd0);
      tick();
      outACK = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (wrDone) begin
            done_cnt++;
            wrReq = 1'b0;
         end
      end
      chk("wrdone_once", 8'(done_cnt), 8'd1);
      chk("out_final", out, 8'h5A);

      // Concurrent IN and OUT
      in          = 8'h11;
      inDataReady = 1'b1;
      wrData      = 8'h22;
      wrReq       = 1'b1;
      n = 0;
      while ((inDataReady || inACK || wrReq || outACK) && n < 40) begin
         tick();
         n++;
         if (inACK) inDataReady = 1'b0;
         if (outDataReady) outACK = 1'b1;
         else if (outACK) outACK = 1'b0;
         if (wrDone) wrReq = 1'b0;
      end
      chk("concurrent_done", 8'(n < 40), 8'd1);
      rdReq = 1'b1;
      tick();
      rdReq = 1'b0;
      chk("conc_rd", rdData, 8'h11);
      chk("conc_out", out, 8'h22);
      tick();

      // Reset in the middle of both handshakes
      in          = 8'h99;
      inDataReady = 1'b1;
      wrData      = 8'h44;
      wrReq       = 1'b1;
      tick();
      chk("pre_rst_ack", 8'(inACK), 8'd1);
      chk("pre_rst_req", 8'(outDataReady), 8'd1);
      reset = 1'b1;
      tick();
      chk("rst_mid", {5'b0, inACK, outDataReady, outBusy}, 8'd0);
      chk("rst_mid_count", 8'(inCount), 8'd0);
      wrReq = 1'b0;
      reset = 1'b0;
      tick();
      chk("rst_retransfer", 8'(inACK), 8'd1);
      inDataReady = 1'b0;
      tick();
      rdReq = 1'b1;
      tick();
      rdReq = 1'b0;
      tick();

      // Randomized traffic with occasional resets
      for (int c = 0; c < 1500; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         if (!inDataReady && !inACK && $urandom_range(0, 2) == 0) begin
            inDataReady = 1'b1;
            in          = 8'($urandom);
         end else if (inDataReady && inACK && $urandom_range(0, 1) == 0) begin
            inDataReady = 1'b0;
         end
         rdReq = 1'($urandom_range(0, 1));
         if (outDataReady && !outACK && $urandom_range(0, 2) == 0) outACK = 1'b1;
         else if (outACK && !outDataReady && $urandom_range(0, 1) == 0) outACK = 1'b0;
         if (wrDone) wrReq = 1'b0;
         else if (!wrReq && !outBusy && $urandom_range(0, 2) == 0) wrReq = 1'b1;
         wrData = 8'($urandom);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
